// File: rtl/transformer_core.sv
// rtl/transformer_core.sv - single-head scalar transformer encoder layer over a streamed Q8.8 sequence
// Optional feed-forward stage: define TRANSFORMER_FFN_EN.
`timescale 1ns/1ps
module transformer_core #(
   parameter int                 SEQ_LEN   = 30,
   parameter int                 ATT_SHIFT = 5,
   parameter logic signed [15:0] WQ        = 16'sh0100,
   parameter logic signed [15:0] WK        = 16'sh0100,
   parameter logic signed [15:0] WV        = 16'sh0100,
   parameter logic signed [15:0] W1        = 16'sh0100,
   parameter logic signed [15:0] W2        = 16'sh0100
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] data_in,
   input  logic        data_in_valid,
   output logic [15:0] data_out,
   output logic        data_out_valid
);

   localparam int            CW   = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;
   localparam logic [CW-1:0] LAST = CW'(SEQ_LEN - 1);

   typedef enum logic [1:0] {S_LOAD, S_ACC, S_FFN, S_OUT} state_t;

   state_t             r_state, w_next;
   logic [CW-1:0]      r_n, r_i, r_j;
   logic signed [39:0] r_acc;
   logic signed [15:0] r_x [SEQ_LEN];
   logic signed [15:0] r_k [SEQ_LEN];
   logic signed [15:0] r_v [SEQ_LEN];

   function automatic logic signed [15:0] sat16(input logic signed [47:0] v);
      if (v > 48'sd32767)
         return 16'sh7FFF;
      else if (v < -48'sd32768)
         return 16'sh8000;
      else
         return v[15:0];
   endfunction

   logic signed [15:0] w_din, w_kin, w_vin, w_xi, w_q, w_s, w_r, w_a, w_h, w_f, w_y;
   logic signed [31:0] w_kp, w_vp, w_qp, w_sp, w_rv;
   logic signed [39:0] w_acc_next;

   assign w_din = $signed(data_in);
   assign w_kp  = WK * w_din;
   assign w_vp  = WV * w_din;
   assign w_kin = sat16(48'(w_kp >>> 8));
   assign w_vin = sat16(48'(w_vp >>> 8));

   // Attention score for (i, j); negative scores are clipped before weighting v[j]
   assign w_xi  = r_x[r_i];
   assign w_qp  = WQ * w_xi;
   assign w_q   = sat16(48'(w_qp >>> 8));
   assign w_sp  = w_q * r_k[r_j];
   assign w_s   = sat16(48'(w_sp >>> 8));
   assign w_r   = w_s[15] ? 16'sd0 : w_s;
   assign w_rv  = w_r * r_v[r_j];
   assign w_acc_next = ((r_j == '0) ? 40'sd0 : r_acc) + 40'(w_rv);

   assign w_a   = sat16(48'(r_acc >>> (8 + ATT_SHIFT)));
   assign w_h   = sat16(48'(w_xi) + 48'(w_a));

`ifdef TRANSFORMER_FFN_EN
   logic signed [31:0] w_f1p, w_f2p;
   logic signed [15:0] w_f1, w_f1r;
   assign w_f1p = W1 * w_h;
   assign w_f1  = sat16(48'(w_f1p >>> 8));
   assign w_f1r = w_f1[15] ? 16'sd0 : w_f1;
   assign w_f2p = w_f1r * W2;
   assign w_f   = sat16(48'(w_f2p >>> 8));
`else
   assign w_f   = 16'sd0;
`endif

   assign w_y   = sat16(48'(w_h) + 48'(w_f));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LOAD: if (data_in_valid && r_n == LAST) w_next = S_ACC;
         S_ACC:  if (r_j == LAST) w_next = S_FFN;
         S_FFN:  w_next = S_OUT;
         S_OUT:  w_next = (r_i == LAST) ? S_LOAD : S_ACC;
         default: w_next = S_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= S_LOAD;
         r_n            <= '0;
         r_i            <= '0;
         r_j            <= '0;
         r_acc          <= '0;
         data_out       <= '0;
         data_out_valid <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_LOAD: begin
               if (data_in_valid)
                  r_n <= (r_n == LAST) ? '0 : r_n + CW'(1);
            end
            S_ACC: begin
               r_acc <= w_acc_next;
               r_j   <= (r_j == LAST) ? '0 : r_j + CW'(1);
            end
            S_FFN: begin
               data_out       <= w_y;
               data_out_valid <= 1'b1;
            end
            S_OUT: begin
               data_out_valid <= 1'b0;
               r_i            <= (r_i == LAST) ? '0 : r_i + CW'(1);
            end
            default: ;
         endcase
      end
   end

   // Token buffers need no reset; they are always rewritten before use
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD && data_in_valid) begin
         r_x[r_n] <= w_din;
         r_k[r_n] <= w_kin;
         r_v[r_n] <= w_vin;
      end
   end

endmodule

// File: tb/tb_transformer_core.sv
// tb/tb_transformer_core.sv - scoreboard bench for transformer_core
`timescale 1ns/1ps
module tb_transformer_core;

   localparam int     N  = 30;
   localparam longint WT = 256;

`ifdef TRANSFORMER_FFN_EN
   localparam logic [15:0] E_ONE = 16'h03E0;
   localparam logic [15:0] E_X0  = 16'h0210;
`else
   localparam logic [15:0] E_ONE = 16'h01F0;
   localparam logic [15:0] E_X0  = 16'h0108;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] data_in = '0;
   logic        data_in_valid = 1'b0;
   logic [15:0] data_out;
   logic        data_out_valid;

   int          n_vec = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_cap = 0;
   int          last_strobe = 0;
   int          k_in_seq = 0;
   logic [15:0] exp_q[$];
   logic [15:0] seq[N];
   logic [15:0] last_exp = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   transformer_core dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_in        (data_in),
      .data_in_valid  (data_in_valid),
      .data_out       (data_out),
      .data_out_valid (data_out_valid)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && data_out_valid) begin
         if (exp_q.size() == 0) begin
            chk("extra_strobe", 32'd1, 32'd0);
         end else begin
            last_exp = exp_q.pop_front();
            chk("out", 32'(data_out), 32'(last_exp));
            if (k_in_seq == 0)
               chk("first_lat", 32'(cyc - last_cap), 32'(N + 1));
            else
               chk("spacing", 32'(cyc - last_strobe), 32'(N + 2));
            last_strobe = cyc;
            k_in_seq    = (k_in_seq == N - 1) ? 0 : k_in_seq + 1;
         end
      end
   end

   function automatic int sat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return int'(v);
   endfunction

   function automatic logic [15:0] model_y(input int i);
      longint x[N];
      longint acc = 0;
      int q, kk, vv, s, r, a, h, f, t;
      for (int j = 0; j < N; j++) x[j] = longint'($signed(seq[j]));
      q = sat((WT * x[i]) >>> 8);
      for (int j = 0; j < N; j++) begin
         kk = sat((WT * x[j]) >>> 8);
         vv = sat((WT * x[j]) >>> 8);
         s  = sat((longint'(q) * kk) >>> 8);
         r  = (s > 0) ? s : 0;
         acc += longint'(r) * longint'(vv);
      end
      a = sat(acc >>> 13);
      h = sat(x[i] + longint'(a));
      f = 0;
`ifdef TRANSFORMER_FFN_EN
      t = sat((WT * h) >>> 8);
      if (t < 0) t = 0;
      f = sat((longint'(t) * WT) >>> 8);
`else
      t = 0;
`endif
      return 16'(sat(longint'(h) + longint'(f) + longint'(t) * 0));
   endfunction

   task automatic send(input logic [15:0] v);
      data_in       = v;
      data_in_valid = 1'b1;
      @(posedge clk);
      #1 last_cap = cyc;
      @(negedge clk);
      data_in_valid = 1'b0;
   endtask

   task automatic load_seq(input bit gaps);
      for (int i = 0; i < N; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               data_in = 16'($urandom);
               data_in_valid = 1'b0;
               @(negedge clk);
            end
         end
         send(seq[i]);
      end
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < N; i++) seq[i] = v;
   endtask

   task automatic push_const(input logic [15:0] v);
      for (int i = 0; i < N; i++) exp_q.push_back(v);
   endtask

   task automatic push_model();
      for (int i = 0; i < N; i++) exp_q.push_back(model_y(i));
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 2 * N * (N + 2)) begin
         @(negedge clk);
         t++;
      end
      chk("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      chk("hold", 32'(data_out), 32'(last_exp));
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_out", 32'(data_out), 32'd0);
      chk("rst_valid", 32'(data_out_valid), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      fill(16'h0000); load_seq(1'b0); push_const(16'h0000); drain();
      fill(16'h0100); load_seq(1'b0); push_const(E_ONE);    drain();
      fill(16'hFF00); load_seq(1'b0); push_const(16'hFE10); drain();
      fill(16'h7FFF); load_seq(1'b0); push_const(16'h7FFF); drain();

      // Single impulse with load gaps, then junk words presented during compute
      fill(16'h0000); seq[0] = 16'h0100;
      load_seq(1'b1);
      exp_q.push_back(E_X0);
      for (int i = 1; i < N; i++) exp_q.push_back(16'h0000);
      repeat (100) begin
         data_in = 16'($urandom);
         data_in_valid = 1'b1;
         @(negedge clk);
      end
      data_in_valid = 1'b0;
      drain();

      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < N; i++)
            seq[i] = (r == 0) ? 16'($urandom_range(0, 2047)) - 16'd1024 : 16'($urandom);
         load_seq(1'b1);
         push_model();
         drain();
      end

      // Reset mid-compute: outputs clear asynchronously, no strobes afterwards
      fill(16'h0100); load_seq(1'b0);
      exp_q.push_back(E_ONE);
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
      chk("pre_rst_strobe", 32'(exp_q.size()), 32'd0);
      repeat (10) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_mid_out", 32'(data_out), 32'd0);
      chk("rst_mid_valid", 32'(data_out_valid), 32'd0);
      k_in_seq = 0;
      last_exp = 16'h0000;
      repeat (40) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("post_rst_out", 32'(data_out), 32'd0);
      fill(16'h0100); load_seq(1'b0); push_const(E_ONE); drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
